pattern_pulse_seq: RTL

Parametrised pattern pulse sequencer. It is the successor to the fixed 16-bit load/rotate pulse generator, adding:
- configurable width
- shift direction
- continuous or counted-repeat mode
- start/stop control with busy/done status

It drives a serial pulse train from a stored pattern. It sits beside the counters as a programmable timing source.

---
 rtl/pattern_pulse_seq_pkg.sv | 15 +
 rtl/pattern_pulse_seq_rotate_reg.sv | 42 ++++
 rtl/pattern_pulse_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pattern_pulse_seq_pkg.sv
// Shared definitions for the pattern pulse sequencer and its rotator.
package pattern_pulse_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_COUNT = 1'b1;
  localparam logic DIR_MSB    = 1'b0;
  localparam logic DIR_LSB    = 1'b1;

endpackage

// File: rtl/pattern_pulse_seq_rotate_reg.sv
// WIDTH-bit circular shift register with reload; reports the bit that will sit
// at the output end after the next rotation.
module rotate_reg
  import pattern_pulse_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             reload,
  input  logic [WIDTH-1:0] reload_val,
  input  logic             shift_en,
  input  logic             dir,
  output logic             nxt_bit
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rot;

  always_comb begin
    rot = q;
    if (dir == DIR_LSB) begin
      rot = {q[0], q[WIDTH-1:1]};
    end else begin
      rot = {q[WIDTH-2:0], q[WIDTH-1]};
    end
  end

  // Output end is the MSB when rotating left, the LSB when rotating right.
  assign nxt_bit = (dir == DIR_LSB) ? rot[0] : rot[WIDTH-1];

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (reload) begin
      q <= reload_val;
    end else if (shift_en) begin
      q <= rot;
    end
  end

endmodule

// File: rtl/pattern_pulse_seq.sv
// Programmable serial pulse train: replays a stored pattern MSB- or LSB-first,
// either continuously or for a counted number of passes.
module pattern_pulse_seq
  import pattern_pulse_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             load,
  input  logic [WIDTH-1:0] load_in,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             dir,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] bit_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] pat_q;
  logic             mode_q;
  logic             dir_q;
  logic [CNT_W-1:0] rcnt_q;
  logic [CNT_W-1:0] pass_q;

  logic             launch;
  logic [WIDTH-1:0] new_pat;
  logic             nxt_bit;
  logic             rot_dir;

  function automatic logic [CNT_W-1:0] clamp_reps(input logic [CNT_W-1:0] r);
    return (r == '0) ? CNT_W'(1) : r;
  endfunction

  function automatic logic first_bit(input logic [WIDTH-1:0] p, input logic d);
    return (d == DIR_LSB) ? p[0] : p[WIDTH-1];
  endfunction

  // A same-cycle load feeds the new pattern straight into the launch.
  assign launch  = (state_q == ST_IDLE) && start && !stop;
  assign new_pat = load ? load_in : pat_q;
  assign rot_dir = launch ? dir : dir_q;

  rotate_reg #(
    .WIDTH(WIDTH)
  ) u_rot (
    .clk       (CLK),
    .clr       (CLR),
    .reload    (launch),
    .reload_val(new_pat),
    .shift_en  (state_q == ST_RUN),
    .dir       (rot_dir),
    .nxt_bit   (nxt_bit)
  );

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q   <= ST_IDLE;
      pat_q     <= '0;
      mode_q    <= MODE_CONT;
      dir_q     <= DIR_MSB;
      rcnt_q    <= '0;
      pass_q    <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_idx   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pulse_out <= 1'b0;
          done      <= 1'b0;
          if (load) begin
            pat_q <= load_in;
          end
          if (launch) begin
            mode_q    <= mode;
            dir_q     <= dir;
            rcnt_q    <= clamp_reps(repeat_cnt);
            pass_q    <= '0;
            bit_idx   <= '0;
            busy      <= 1'b1;
            pulse_out <= first_bit(new_pat, dir);
            state_q   <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (stop) begin
            state_q   <= ST_IDLE;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            bit_idx   <= '0;
          end else if (bit_idx == LAST_IDX) begin
            // End of a pass: either finish a counted run or wrap to bit 0.
            bit_idx <= '0;
            pass_q  <= pass_q + CNT_W'(1);
            if ((mode_q == MODE_COUNT) && (pass_q == rcnt_q - CNT_W'(1))) begin
              state_q   <= ST_DONE;
              pulse_out <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              pulse_out <= nxt_bit;
            end
          end else begin
            bit_idx   <= bit_idx + IDX_W'(1);
            pulse_out <= nxt_bit;
          end
        end

        ST_DONE: begin
          done      <= 1'b0;
          pulse_out <= 1'b0;
          state_q   <= ST_IDLE;
        end

        default: begin
          state_q   <= ST_IDLE;
          pulse_out <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          bit_idx   <= '0;
        end
      endcase
    end
  end

endmodule
